mul_div_unit: RTL and testbench
===============================

Name: mul_div_unit

Overview:
- Iterative 32-bit multiply/divide unit for the multi-cycle CPU.
- Sits directly downstream of the A and B non-architectural operand registers and consumes their outputs.
- Executes MULT/MULTU/DIV/DIVU over WIDTH cycles and produces HI/LO results.
- The control FSM starts it with a one-cycle pulse and stalls on o_busy until o_done.

Parameters:
WIDTH, 32, operand width; latency in iteration cycles equals WIDTH

Ports:
i_clk  input  1  system clock, rising-edge
i_rst_n  input  1  asynchronous active-low reset
i_start  input  1  one-cycle request pulse; sampled only in IDLE or DONE
i_op  input  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV; sampled with i_start
i_a  input  WIDTH  multiplicand / dividend (from A register)
i_b  input  WIDTH  multiplier / divisor (from B register)
o_busy  output  1  high while iterating
o_done  output  1  one-cycle pulse when o_hi/o_lo are updated
o_hi  output  WIDTH  product upper half / remainder
o_lo  output  WIDTH  product lower half / quotient
o_div_by_zero  output  1  set with o_done when a divide had i_b == 0; held until next o_done

Behaviour:
- Interface: one clock (i_clk); reset is asynchronous and active-low (i_rst_n).
- Reset, including mid-operation: state IDLE, iteration counter 0, all outputs 0. Any in-flight result is discarded and no o_done is issued.
- FSM states are IDLE, RUN and DONE.
  - IDLE or DONE with i_start=1 at edge E: latch i_a, i_b and i_op, record signs, convert to magnitudes for signed ops, clear the accumulator, go to RUN.
  - RUN: one shift-add (multiply) or restoring shift-subtract (divide) step per edge, at edges E+1..E+WIDTH. At E+WIDTH, write sign-corrected results to o_hi/o_lo and go to DONE.
  - DONE: o_done=1 for exactly this cycle. Without i_start, return to IDLE at the next edge; with i_start, start a new operation (back-to-back allowed).
- o_busy=1 exactly in RUN, i.e. WIDTH cycles. o_done is never high together with o_busy.
- i_start during RUN is ignored. Operands are latched, so i_a/i_b may change freely after E.
- o_hi, o_lo and o_div_by_zero change only at the DONE transition and otherwise hold.
- Multiply: the 2*WIDTH-bit product is {o_hi,o_lo}. For MULT, the product is negated if the operand signs differ.
- Divide:
  - o_lo is the quotient and o_hi the remainder.
  - For DIV, the quotient is negated if the signs differ, and the remainder takes the dividend's sign (truncating division).
- Divide by zero: full latency still elapses; o_lo = all ones, o_hi = i_a as latched, o_div_by_zero = 1.
- DIV of most-negative by -1: o_lo = 0x80000000, o_hi = 0, no flag.
- Magnitude of the most-negative operand is handled as an unsigned WIDTH-bit value; no extra bit is lost.

Decomposition:
- Shared header/package holds:
  - op encodings (OP_MULTU=2'b00, OP_MULT=2'b01, OP_DIVU=2'b10, OP_DIV=2'b11);
  - state encodings (IDLE, RUN, DONE);
  - default WIDTH.
- One natural sub-module, mul_div_step: a combinational single-iteration datapath (add or trial-subtract plus shift) instantiated once. Sequencing, sign fix-up and output registers stay in mul_div_unit.

Test Plan:
- MULTU with i_a=0xFFFFFFFF, i_b=0xFFFFFFFF, i_start at edge 0 -> o_busy high for 32 cycles; o_done pulses once after edge 32; o_hi=0xFFFFFFFE, o_lo=0x00000001.
- MULT with i_a=-3, i_b=5 -> o_hi=0xFFFFFFFF, o_lo=0xFFFFFFF1.
- DIVU 100/7 -> o_lo=14, o_hi=2. Then DIV -7/2 started in the DONE cycle (back-to-back) -> o_lo=0xFFFFFFFD, o_hi=0xFFFFFFFF, o_div_by_zero=0.
- DIVU 0x1234/0 -> o_lo=0xFFFFFFFF, o_hi=0x00001234, o_div_by_zero=1. The next MULTU 2*3 -> flag clears, o_lo=6.
- Start MULTU 7*9; at cycle 10 pulse i_start with DIVU and change i_a/i_b -> second start ignored; result o_lo=63, o_hi=0 after the original latency.
- Start DIV; assert i_rst_n=0 asynchronously at cycle 15 -> outputs 0, o_busy=0 immediately, no o_done. After release, a new MULT -1*-1 -> o_hi=0, o_lo=1.

Source files
------------

// File: rtl/mul_div_unit_pkg.sv
// Shared encodings for the iterative multiply/divide unit: operation codes,
// control states and the default operand width.
package mul_div_unit_pkg;

  localparam int DEFAULT_WIDTH = 32;

  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_MULT  = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_DIV   = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/mul_div_step.sv
// One iteration of the shared datapath: shift-add for multiply, restoring
// shift-subtract for divide. Purely combinational.
module mul_div_step
  import mul_div_unit_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH-1:0] acc_next,
  output logic [WIDTH-1:0] q_next
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // Multiply keeps the running high half in acc and shifts product bits into q;
  // divide shifts dividend bits out of q into the partial remainder in acc.
  always_comb begin
    sum      = {1'b0, acc} + (q[0] ? {1'b0, m} : '0);
    shifted  = {acc, q[WIDTH-1]};
    diff     = shifted - {1'b0, m};
    acc_next = sum[WIDTH:1];
    q_next   = {sum[0], q[WIDTH-1:1]};
    if (is_div) begin
      if (!diff[WIDTH]) begin
        acc_next = diff[WIDTH-1:0];
        q_next   = {q[WIDTH-2:0], 1'b1};
      end else begin
        acc_next = shifted[WIDTH-1:0];
        q_next   = {q[WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit: latches operands on i_start, iterates
// WIDTH cycles through mul_div_step, then sign-corrects into HI/LO.
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [1:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo,
  output logic             o_div_by_zero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [1:0]       state;
  logic [CW-1:0]    count;
  logic             is_div;
  logic             neg_res;
  logic             neg_rem;
  logic             div0;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] m;
  logic [WIDTH-1:0] a_raw;

  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  logic [WIDTH-1:0]   acc_next;
  logic [WIDTH-1:0]   q_next;
  logic [2*WIDTH-1:0] product;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix;
  logic [WIDTH-1:0]   rem_fix;

  // Magnitudes stay WIDTH bits wide: the most-negative value maps to itself,
  // which is exactly its unsigned magnitude.
  always_comb begin
    a_neg = i_op[0] & i_a[WIDTH-1];
    b_neg = i_op[0] & i_b[WIDTH-1];
    a_mag = a_neg ? -i_a : i_a;
    b_mag = b_neg ? -i_b : i_b;
  end

  mul_div_step #(.WIDTH(WIDTH)) u_step (
    .is_div   (is_div),
    .acc      (acc),
    .q        (q),
    .m        (m),
    .acc_next (acc_next),
    .q_next   (q_next)
  );

  always_comb begin
    product  = {acc_next, q_next};
    prod_fix = neg_res ? -product : product;
    quot_fix = neg_res ? -q_next : q_next;
    rem_fix  = neg_rem ? -acc_next : acc_next;
  end

  assign o_busy = (state == ST_RUN);
  assign o_done = (state == ST_DONE);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state         <= ST_IDLE;
      count         <= '0;
      is_div        <= 1'b0;
      neg_res       <= 1'b0;
      neg_rem       <= 1'b0;
      div0          <= 1'b0;
      acc           <= '0;
      q             <= '0;
      m             <= '0;
      a_raw         <= '0;
      o_hi          <= '0;
      o_lo          <= '0;
      o_div_by_zero <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (i_start) begin
            state   <= ST_RUN;
            count   <= '0;
            is_div  <= i_op[1];
            neg_res <= a_neg ^ b_neg;
            neg_rem <= a_neg;
            div0    <= i_op[1] & (i_b == '0);
            acc     <= '0;
            q       <= a_mag;
            m       <= b_mag;
            a_raw   <= i_a;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          acc   <= acc_next;
          q     <= q_next;
          count <= count + 1'b1;
          if (count == LAST) begin
            state <= ST_DONE;
            count <= '0;
            if (!is_div) begin
              o_hi          <= prod_fix[2*WIDTH-1:WIDTH];
              o_lo          <= prod_fix[WIDTH-1:0];
              o_div_by_zero <= 1'b0;
            end else if (div0) begin
              o_hi          <= a_raw;
              o_lo          <= '1;
              o_div_by_zero <= 1'b1;
            end else begin
              o_hi          <= rem_fix;
              o_lo          <= quot_fix;
              o_div_by_zero <= 1'b0;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed corner cases plus randomized
// operations checked against a plain-arithmetic reference model.
module tb_mul_div_unit;

  localparam int W = 32;

  logic         i_clk;
  logic         i_rst_n;
  logic         i_start;
  logic [1:0]   i_op;
  logic [W-1:0] i_a;
  logic [W-1:0] i_b;
  logic         o_busy;
  logic         o_done;
  logic [W-1:0] o_hi;
  logic [W-1:0] o_lo;
  logic         o_div_by_zero;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } vec_t;

  mul_div_unit #(.WIDTH(W)) dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_start       (i_start),
    .i_op          (i_op),
    .i_a           (i_a),
    .i_b           (i_b),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_hi          (o_hi),
    .o_lo          (o_lo),
    .o_div_by_zero (o_div_by_zero)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference: plain 64-bit arithmetic; SV division truncates toward zero
  // and the remainder follows the dividend, matching DIV semantics.
  function automatic void ref_model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] hi, output logic [31:0] lo, output logic dbz);
    longint sa, sb, qq, rr;
    logic [63:0] p;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    dbz = 1'b0;
    hi  = '0;
    lo  = '0;
    if (op == 2'b00) begin
      p  = {32'b0, a} * {32'b0, b};
      hi = p[63:32];
      lo = p[31:0];
    end else if (op == 2'b01) begin
      p  = sa * sb;
      hi = p[63:32];
      lo = p[31:0];
    end else if (b == 32'b0) begin
      hi  = a;
      lo  = '1;
      dbz = 1'b1;
    end else if (op == 2'b10) begin
      lo = a / b;
      hi = a % b;
    end else begin
      qq = sa / sb;
      rr = sa % sb;
      lo = qq[31:0];
      hi = rr[31:0];
    end
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  // Drives a start at the current sample point and waits for o_done,
  // scrambling the operand inputs after the start edge.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int busy_cycles, output bit timed_out);
    i_op    = op;
    i_a     = a;
    i_b     = b;
    i_start = 1'b1;
    @(posedge i_clk);
    #1;
    i_start     = 1'b0;
    i_a         = $urandom;
    i_b         = $urandom;
    i_op        = 2'($urandom_range(0, 3));
    busy_cycles = 0;
    timed_out   = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (o_done) begin
        timed_out = 1'b0;
        break;
      end
      if (o_busy) busy_cycles++;
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    i_start = 1'b0;
    i_op    = '0;
    i_a     = '0;
    i_b     = '0;
    idle(2);
    n_cmp++; if (o_busy !== 1'b0) begin n_err++; $display("[TB] FAIL reset_busy: got %b expected 0", o_busy); end
    n_cmp++; if (o_done !== 1'b0) begin n_err++; $display("[TB] FAIL reset_done: got %b expected 0", o_done); end
    n_cmp++; if (o_hi !== 32'h0) begin n_err++; $display("[TB] FAIL reset_hi: got %h expected 0", o_hi); end
    n_cmp++; if (o_lo !== 32'h0) begin n_err++; $display("[TB] FAIL reset_lo: got %h expected 0", o_lo); end
    n_cmp++; if (o_div_by_zero !== 1'b0) begin n_err++; $display("[TB] FAIL reset_dbz: got %b expected 0", o_div_by_zero); end
    @(negedge i_clk);
    i_rst_n = 1'b1;
    idle(1);
  endtask

  task automatic test_multu_max();
    int  busy;
    bit  to;
    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, busy, to);
    n_cmp++; if (to !== 1'b0) begin n_err++; $display("[TB] FAIL multu_max_timeout: no o_done within bound"); end
    n_cmp++; if (busy !== 32) begin n_err++; $display("[TB] FAIL multu_max_busy: got %0d cycles expected 32", busy); end
    n_cmp++; if (o_busy !== 1'b0) begin n_err++; $display("[TB] FAIL multu_max_busy_with_done: got %b expected 0", o_busy); end
    n_cmp++; if (o_hi !== 32'hFFFF_FFFE) begin n_err++; $display("[TB] FAIL multu_max_hi: got %h expected fffffffe", o_hi); end
    n_cmp++; if (o_lo !== 32'h0000_0001) begin n_err++; $display("[TB] FAIL multu_max_lo: got %h expected 00000001", o_lo); end
    idle(1);
    n_cmp++; if (o_done !== 1'b0) begin n_err++; $display("[TB] FAIL done_one_cycle: got %b expected 0", o_done); end
    idle(2);
    n_cmp++; if (o_hi !== 32'hFFFF_FFFE) begin n_err++; $display("[TB] FAIL multu_max_hold_hi: got %h expected fffffffe", o_hi); end
  endtask

  task automatic test_directed();
    vec_t v[6];
    int   busy;
    bit   to;
    v[0] = '{2'b01, 32'hFFFF_FFFD, 32'd5,        32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0};
    v[1] = '{2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,        32'h8000_0000, 1'b0};
    v[2] = '{2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0,        1'b0};
    v[3] = '{2'b11, 32'd7,        32'hFFFF_FFFE, 32'd1,        32'hFFFF_FFFD, 1'b0};
    v[4] = '{2'b11, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd3,        1'b0};
    v[5] = '{2'b10, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'd1,        1'b0};
    foreach (v[i]) begin
      idle(1);
      run_op(v[i].op, v[i].a, v[i].b, busy, to);
      n_cmp++; if (to !== 1'b0) begin n_err++; $display("[TB] FAIL directed%0d_timeout: no o_done within bound", i); end
      n_cmp++; if (o_hi !== v[i].hi) begin n_err++; $display("[TB] FAIL directed%0d_hi: got %h expected %h", i, o_hi, v[i].hi); end
      n_cmp++; if (o_lo !== v[i].lo) begin n_err++; $display("[TB] FAIL directed%0d_lo: got %h expected %h", i, o_lo, v[i].lo); end
      n_cmp++; if (o_div_by_zero !== v[i].dbz) begin n_err++; $display("[TB] FAIL directed%0d_dbz: got %b expected %b", i, o_div_by_zero, v[i].dbz); end
    end
  endtask

  task automatic test_back_to_back();
    int busy;
    bit to;
    idle(1);
    run_op(2'b10, 32'd100, 32'd7, busy, to);
    n_cmp++; if (to !== 1'b0) begin n_err++; $display("[TB] FAIL b2b_first_timeout: no o_done within bound"); end
    n_cmp++; if (o_lo !== 32'd14) begin n_err++; $display("[TB] FAIL b2b_divu_lo: got %h expected 0000000e", o_lo); end
    n_cmp++; if (o_hi !== 32'd2) begin n_err++; $display("[TB] FAIL b2b_divu_hi: got %h expected 00000002", o_hi); end
    run_op(2'b11, 32'hFFFF_FFF9, 32'd2, busy, to);
    n_cmp++; if (to !== 1'b0) begin n_err++; $display("[TB] FAIL b2b_second_timeout: no o_done within bound"); end
    n_cmp++; if (busy !== 32) begin n_err++; $display("[TB] FAIL b2b_busy: got %0d cycles expected 32", busy); end
    n_cmp++; if (o_lo !== 32'hFFFF_FFFD) begin n_err++; $display("[TB] FAIL b2b_div_lo: got %h expected fffffffd", o_lo); end
    n_cmp++; if (o_hi !== 32'hFFFF_FFFF) begin n_err++; $display("[TB] FAIL b2b_div_hi: got %h expected ffffffff", o_hi); end
    n_cmp++; if (o_div_by_zero !== 1'b0) begin n_err++; $display("[TB] FAIL b2b_div_dbz: got %b expected 0", o_div_by_zero); end
  endtask

  task automatic test_div_zero();
    int busy;
    bit to;
    idle(1);
    run_op(2'b10, 32'h0000_1234, 32'd0, busy, to);
    n_cmp++; if (to !== 1'b0) begin n_err++; $display("[TB] FAIL dbz_timeout: no o_done within bound"); end
    n_cmp++; if (busy !== 32) begin n_err++; $display("[TB] FAIL dbz_busy: got %0d cycles expected 32", busy); end
    n_cmp++; if (o_lo !== 32'hFFFF_FFFF) begin n_err++; $display("[TB] FAIL dbz_lo: got %h expected ffffffff", o_lo); end
    n_cmp++; if (o_hi !== 32'h0000_1234) begin n_err++; $display("[TB] FAIL dbz_hi: got %h expected 00001234", o_hi); end
    n_cmp++; if (o_div_by_zero !== 1'b1) begin n_err++; $display("[TB] FAIL dbz_flag: got %b expected 1", o_div_by_zero); end
    idle(3);
    n_cmp++; if (o_div_by_zero !== 1'b1) begin n_err++; $display("[TB] FAIL dbz_flag_hold: got %b expected 1", o_div_by_zero); end
    run_op(2'b00, 32'd2, 32'd3, busy, to);
    n_cmp++; if (o_div_by_zero !== 1'b0) begin n_err++; $display("[TB] FAIL dbz_flag_clear: got %b expected 0", o_div_by_zero); end
    n_cmp++; if (o_lo !== 32'd6) begin n_err++; $display("[TB] FAIL dbz_next_lo: got %h expected 00000006", o_lo); end
  endtask

  task automatic test_ignore_start();
    int  edges;
    bit  to;
    idle(1);
    i_op    = 2'b00;
    i_a     = 32'd7;
    i_b     = 32'd9;
    i_start = 1'b1;
    @(posedge i_clk);
    #1;
    i_start = 1'b0;
    edges   = 0;
    repeat (9) begin
      @(posedge i_clk);
      #1;
      edges++;
    end
    i_op    = 2'b10;
    i_a     = 32'd100;
    i_b     = 32'd3;
    i_start = 1'b1;
    @(posedge i_clk);
    #1;
    edges++;
    i_start = 1'b0;
    to      = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (o_done) begin
        to = 1'b0;
        break;
      end
      @(posedge i_clk);
      #1;
      edges++;
    end
    n_cmp++; if (to !== 1'b0) begin n_err++; $display("[TB] FAIL ignore_timeout: no o_done within bound"); end
    n_cmp++; if (edges !== 32) begin n_err++; $display("[TB] FAIL ignore_latency: got %0d edges expected 32", edges); end
    n_cmp++; if (o_lo !== 32'd63) begin n_err++; $display("[TB] FAIL ignore_lo: got %h expected 0000003f", o_lo); end
    n_cmp++; if (o_hi !== 32'd0) begin n_err++; $display("[TB] FAIL ignore_hi: got %h expected 00000000", o_hi); end
  endtask

  task automatic test_reset_mid_op();
    bit done_seen;
    int busy;
    bit to;
    idle(1);
    i_op    = 2'b11;
    i_a     = 32'hFFFF_FF9C;
    i_b     = 32'd7;
    i_start = 1'b1;
    @(posedge i_clk);
    #1;
    i_start = 1'b0;
    idle(15);
    #2;
    i_rst_n = 1'b0;
    #1;
    n_cmp++; if (o_busy !== 1'b0) begin n_err++; $display("[TB] FAIL midrst_busy: got %b expected 0", o_busy); end
    n_cmp++; if (o_lo !== 32'h0) begin n_err++; $display("[TB] FAIL midrst_lo: got %h expected 0", o_lo); end
    n_cmp++; if (o_hi !== 32'h0) begin n_err++; $display("[TB] FAIL midrst_hi: got %h expected 0", o_hi); end
    done_seen = 1'b0;
    repeat (3) begin
      @(posedge i_clk);
      #1;
      done_seen |= o_done;
    end
    @(negedge i_clk);
    i_rst_n = 1'b1;
    repeat (40) begin
      @(posedge i_clk);
      #1;
      done_seen |= o_done;
    end
    n_cmp++; if (done_seen !== 1'b0) begin n_err++; $display("[TB] FAIL midrst_no_done: got %b expected 0", done_seen); end
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, busy, to);
    n_cmp++; if (to !== 1'b0) begin n_err++; $display("[TB] FAIL midrst_next_timeout: no o_done within bound"); end
    n_cmp++; if (o_hi !== 32'h0) begin n_err++; $display("[TB] FAIL midrst_next_hi: got %h expected 00000000", o_hi); end
    n_cmp++; if (o_lo !== 32'h1) begin n_err++; $display("[TB] FAIL midrst_next_lo: got %h expected 00000001", o_lo); end
  endtask

  task automatic test_random();
    logic [1:0]  op;
    logic [31:0] a, b, exp_hi, exp_lo;
    logic        exp_dbz;
    int          busy;
    bit          to;
    idle(1);
    for (int n = 0; n < 60; n++) begin
      op = 2'($urandom_range(0, 3));
      a  = pick_operand();
      b  = pick_operand();
      ref_model(op, a, b, exp_hi, exp_lo, exp_dbz);
      if ($urandom_range(0, 1) == 0) idle($urandom_range(1, 3));
      run_op(op, a, b, busy, to);
      n_cmp++; if (to !== 1'b0 || busy !== 32) begin n_err++; $display("[TB] FAIL rand%0d_latency: got %0d busy cycles (timeout %b) expected 32", n, busy, to); end
      n_cmp++; if (o_hi !== exp_hi) begin n_err++; $display("[TB] FAIL rand%0d_hi: op %b a %h b %h got %h expected %h", n, op, a, b, o_hi, exp_hi); end
      n_cmp++; if (o_lo !== exp_lo) begin n_err++; $display("[TB] FAIL rand%0d_lo: op %b a %h b %h got %h expected %h", n, op, a, b, o_lo, exp_lo); end
      n_cmp++; if (o_div_by_zero !== exp_dbz) begin n_err++; $display("[TB] FAIL rand%0d_dbz: got %b expected %b", n, o_div_by_zero, exp_dbz); end
    end
  endtask

  initial begin
    test_reset();
    test_multu_max();
    test_directed();
    test_back_to_back();
    test_div_zero();
    test_ignore_start();
    test_reset_mid_op();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
